// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  // Instructions are one halfword.
  localparam int unsigned PC_INC = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue holding {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W-1:0] wptr_q;
  logic [CNT_W-1:0] count_q;

  // Pointers and occupancy; flush takes priority over push and pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: the head is only meaningful while count is non-zero.
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wptr_q] <= wdata;
  end

  assign count = count_q;
  assign head  = mem_q[rptr_q];

  push_not_full: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !flush && count_q == CNT_W'(DEPTH)));

  pop_not_empty: assert property (@(posedge clock) disable iff (!reset_n)
    !(pop && !flush && count_q == '0));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, talks req/ack to instruction memory, buffers words for decode
// and squashes wrong-path fetches on a branch redirect.
module instr_fetch_unit #(
  parameter int unsigned               DEPTH    = 2,
  parameter int unsigned               ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic        [ADDR_W-1:0]  RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  output logic                        imem_req,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic                        imem_ack,
  input  logic [cpu_pkg::INSTR_W-1:0] imem_rdata,
  output logic                        ir_valid,
  input  logic                        ir_ready,
  output logic [cpu_pkg::INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]           ir_pc,
  output logic [ADDR_W-1:0]           pc_plus2,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_target
);

  import cpu_pkg::*;

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_e         state_q, state_d;
  logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]    drop_addr_q, drop_addr_d;
  logic [ADDR_W-1:0]    target;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic [ENTRY_W-1:0]   head;
  logic                 push;
  logic                 pop;
  logic                 space_avail;

  assign target   = {redirect_target[ADDR_W-1:1], 1'b0};
  assign ir_valid = (count != '0);

  // A redirect flushes the queue, so it also suppresses this cycle's push and pop.
  assign push = (state_q == StReq) && imem_ack && !redirect_valid;
  assign pop  = ir_valid && ir_ready && !redirect_valid;

  assign count_next  = redirect_valid ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  assign space_avail = (count_next < CNT_W'(DEPTH));

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wdata   ({fetch_pc_q, imem_rdata}),
    .count   (count),
    .head    (head)
  );

  // State, fetch PC and the address held while a squashed request drains.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // Next-state and memory request generation.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    imem_req    = 1'b0;
    imem_addr   = fetch_pc_q;
    unique case (state_q)
      StIdle: begin
        // Acks seen here are stray and ignored.
        if (redirect_valid) begin
          fetch_pc_d = target;
          state_d    = StReq;
        end else if (space_avail) begin
          state_d = StReq;
        end
      end
      StReq: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          fetch_pc_d = target;
          if (imem_ack) begin
            state_d = StReq;
          end else begin
            // Memory still owes us this word: keep its address up until it answers.
            drop_addr_d = fetch_pc_q;
            state_d     = StDrop;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
          state_d    = space_avail ? StReq : StIdle;
        end
      end
      StDrop: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        if (redirect_valid) fetch_pc_d = target;
        // The discarded request is complete once acked, even if a newer redirect lands now.
        if (imem_ack) state_d = StReq;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Decode-facing outputs come straight from the registered queue head, zeroed when empty.
  always_comb begin
    ir    = '0;
    ir_pc = '0;
    if (ir_valid) begin
      ir    = head[INSTR_W-1:0];
      ir_pc = head[ENTRY_W-1:INSTR_W];
    end
    pc_plus2 = ir_pc + ADDR_W'(PC_INC);
  end

endmodule
